// File: rtl/gcd_client_pkg.sv
`default_nettype none
// =============================================================================
// gcd_client_pkg : shared state type, LFSR step and message field slices
// Rev 1.0
// =============================================================================
package gcd_client_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [15:0] LFSR_POLY = 16'hB400;

   localparam int FIELD_W       = 16;
   localparam int CMD_COUNT_LSB = 16;
   localparam int CMD_SEED_LSB  = 0;
   localparam int REQ_A_LSB     = 16;
   localparam int REQ_B_LSB     = 0;

   // One step of the 16-bit Galois LFSR.
   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? LFSR_POLY : 16'h0000);
   endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_client_lfsr.sv
`default_nettype none
// =============================================================================
// gcd_client_lfsr : operand generator; exposes the current value and its successor
// Rev 1.0
// =============================================================================
module gcd_client_lfsr
   import gcd_client_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] cur,
   output logic [15:0] nxt
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   assign cur = lfsr_q;
   assign nxt = lfsr_next(lfsr_q);

   // Each request consumes two LFSR steps (a and b), and the all-zero lock-up
   // state is never allowed in as a seed.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = (seed == 16'h0000) ? 16'h0001 : seed;
      end else if (advance) begin
         lfsr_d = lfsr_next(nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= 16'h0000;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/gcd_client_src.sv
`default_nettype none
// =============================================================================
// gcd_client_src : GCD request source with bounded in-flight count and response checksum
// Optional: define GCD_CLIENT_SRC_CYCLES_EN to add the done_cycles RUN-cycle counter.
// Rev 1.0
// =============================================================================
module gcd_client_src
   import gcd_client_pkg::*;
#(
   parameter int MAX_INFLIGHT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_val,
   output logic        cmd_rdy,
   input  logic [31:0] cmd_msg,
   output logic        req_val,
   input  logic        req_rdy,
   output logic [31:0] req_msg,
   input  logic        resp_val,
   output logic        resp_rdy,
   input  logic [15:0] resp_msg,
`ifdef GCD_CLIENT_SRC_CYCLES_EN
   output logic [31:0] done_cycles,
`endif
   output logic        done_val,
   input  logic        done_rdy,
   output logic [31:0] done_msg
);

   localparam int             IW      = $clog2(MAX_INFLIGHT + 1);
   localparam logic [IW-1:0]  MAX_INF = IW'(MAX_INFLIGHT);

   state_e         state_q,    state_d;
   logic [15:0]    count_q,    count_d;
   logic [15:0]    sent_q,     sent_d;
   logic [15:0]    recvd_q,    recvd_d;
   logic [IW-1:0]  inflight_q, inflight_d;
   logic [31:0]    sum_q,      sum_d;

   logic           cmd_fire;
   logic           req_fire;
   logic           resp_fire;
   logic           done_fire;
   logic [15:0]    cmd_count;
   logic [15:0]    lfsr_cur;
   logic [15:0]    lfsr_nxt;

   assign cmd_count = cmd_msg[CMD_COUNT_LSB +: FIELD_W];

   assign cmd_rdy  = (state_q == IDLE);
   assign req_val  = (state_q == RUN) && (sent_q < count_q) && (inflight_q < MAX_INF);
   assign resp_rdy = (state_q == RUN) && (inflight_q != '0);
   assign done_val = (state_q == DONE);
   assign done_msg = sum_q;
   assign req_msg  = {lfsr_cur, lfsr_nxt};

   assign cmd_fire  = cmd_val  && cmd_rdy;
   assign req_fire  = req_val  && req_rdy;
   assign resp_fire = resp_val && resp_rdy;
   assign done_fire = done_val && done_rdy;

   gcd_client_lfsr u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (cmd_fire),
      .seed    (cmd_msg[CMD_SEED_LSB +: FIELD_W]),
      .advance (req_fire),
      .cur     (lfsr_cur),
      .nxt     (lfsr_nxt)
   );

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      sent_d     = sent_q;
      recvd_d    = recvd_q;
      inflight_d = inflight_q;
      sum_d      = sum_q;
      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               count_d    = cmd_count;
               sent_d     = '0;
               recvd_d    = '0;
               inflight_d = '0;
               sum_d      = '0;
               state_d    = (cmd_count == 16'h0000) ? DONE : RUN;
            end
         end
         RUN: begin
            if (req_fire) begin
               sent_d = sent_q + 16'd1;
            end
            // A simultaneous issue and retire leaves the in-flight count as is.
            if (req_fire && !resp_fire) begin
               inflight_d = inflight_q + IW'(1);
            end else if (resp_fire && !req_fire) begin
               inflight_d = inflight_q - IW'(1);
            end
            if (resp_fire) begin
               recvd_d = recvd_q + 16'd1;
               sum_d   = sum_q + {16'h0000, resp_msg};
               if (recvd_d == count_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (done_fire) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         sent_q     <= '0;
         recvd_q    <= '0;
         inflight_q <= '0;
         sum_q      <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         sent_q     <= sent_d;
         recvd_q    <= recvd_d;
         inflight_q <= inflight_d;
         sum_q      <= sum_d;
      end
   end

`ifdef GCD_CLIENT_SRC_CYCLES_EN
   logic [31:0] cycles_q;
   logic [31:0] cycles_d;

   always_comb begin
      cycles_d = cycles_q;
      if (cmd_fire) begin
         cycles_d = '0;
      end else if ((state_q == RUN) && (cycles_q != 32'hFFFF_FFFF)) begin
         cycles_d = cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycles_q <= '0;
      end else begin
         cycles_q <= cycles_d;
      end
   end

   assign done_cycles = cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_client_src.sv
`default_nettype none
// =============================================================================
// tb_gcd_client_src : directed jobs against a software LFSR/GCD model of the client
// Rev 1.0
// =============================================================================
module tb_gcd_client_src;

   localparam int MAX_INFLIGHT = 2;

   logic        clk;
   logic        reset;
   logic        cmd_val;
   logic        cmd_rdy;
   logic [31:0] cmd_msg;
   logic        req_val;
   logic        req_rdy;
   logic [31:0] req_msg;
   logic        resp_val;
   logic        resp_rdy;
   logic [15:0] resp_msg;
   logic        done_val;
   logic        done_rdy;
   logic [31:0] done_msg;
`ifdef GCD_CLIENT_SRC_CYCLES_EN
   logic [31:0] done_cycles;
`endif

   gcd_client_src #(.MAX_INFLIGHT(MAX_INFLIGHT)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_val     (cmd_val),
      .cmd_rdy     (cmd_rdy),
      .cmd_msg     (cmd_msg),
      .req_val     (req_val),
      .req_rdy     (req_rdy),
      .req_msg     (req_msg),
      .resp_val    (resp_val),
      .resp_rdy    (resp_rdy),
      .resp_msg    (resp_msg),
`ifdef GCD_CLIENT_SRC_CYCLES_EN
      .done_cycles (done_cycles),
`endif
      .done_val    (done_val),
      .done_rdy    (done_rdy),
      .done_msg    (done_msg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int hold_until = 0;
   bit rand_rdy   = 1'b0;
   bit checking   = 1'b0;

   // Fire flags seen at the falling edge, consumed by the responder after the rising edge.
   bit          f_req, f_resp, f_rst;
   logic [15:0] f_a, f_b;
   logic [15:0] rq[$];
   logic [31:0] req_log[$];
   int          job_base;

   // Model of the client: job phase, counters and expected LFSR position.
   int          m_phase;   // 0 idle, 1 run, 2 done
   int          m_count, m_sent, m_recvd, m_inflight, m_cycles;
   logic [15:0] m_l;
   logic [31:0] m_exp_sum;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic int unsigned gcd16(input int unsigned a, input int unsigned b);
      int unsigned x = a;
      int unsigned y = b;
      int unsigned t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic logic [31:0] job_sum(input int cnt, input logic [15:0] seed);
      logic [15:0] l = (seed == 16'h0000) ? 16'h0001 : seed;
      logic [31:0] s = 32'h0;
      for (int i = 0; i < cnt; i++) begin
         s = s + 32'(gcd16(32'(l), 32'(lfsr_nx(l))));
         l = lfsr_nx(lfsr_nx(l));
      end
      return s;
   endfunction

   function automatic logic [31:0] logged(input int idx);
      if (idx < req_log.size()) return req_log[idx];
      return 32'hDEAD_DEAD;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic finish_bench();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   endtask

   task automatic abort(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout waiting on DUT (t=%0t)", name, $time);
      finish_bench();
   endtask

   // Compare process: check outputs against the model, then apply the fires
   // that the coming rising edge will perform.
   always @(negedge clk) begin
      f_req  = 1'b0;
      f_resp = 1'b0;
      f_rst  = reset;
      if (checking) begin
         case (m_phase)
            0: begin
               chk("idle_cmd_rdy",  32'(cmd_rdy),  32'd1);
               chk("idle_req_val",  32'(req_val),  32'd0);
               chk("idle_resp_rdy", 32'(resp_rdy), 32'd0);
               chk("idle_done_val", 32'(done_val), 32'd0);
            end
            1: begin
               chk("run_cmd_rdy", 32'(cmd_rdy), 32'd0);
               chk("run_req_val", 32'(req_val),
                   32'((m_sent < m_count) && (m_inflight < MAX_INFLIGHT)));
               if (req_val) chk("run_req_msg", req_msg, {m_l, lfsr_nx(m_l)});
               chk("run_resp_rdy", 32'(resp_rdy), 32'(m_inflight != 0));
               chk("run_done_val", 32'(done_val), 32'd0);
            end
            default: begin
               chk("done_cmd_rdy",  32'(cmd_rdy),  32'd0);
               chk("done_req_val",  32'(req_val),  32'd0);
               chk("done_resp_rdy", 32'(resp_rdy), 32'd0);
               chk("done_val",      32'(done_val), 32'd1);
               chk("done_msg",      done_msg,      m_exp_sum);
`ifdef GCD_CLIENT_SRC_CYCLES_EN
               chk("done_cycles",   done_cycles,   32'(m_cycles));
`endif
            end
         endcase
      end
      if (reset) begin
         m_phase = 0; m_count = 0; m_sent = 0; m_recvd = 0; m_inflight = 0;
      end else begin
         if (req_val && req_rdy) begin
            f_req = 1'b1;
            f_a   = req_msg[31:16];
            f_b   = req_msg[15:0];
            req_log.push_back(req_msg);
         end
         if (resp_val && resp_rdy) f_resp = 1'b1;
         case (m_phase)
            0: if (cmd_val && cmd_rdy) begin
               m_count    = int'(cmd_msg[31:16]);
               m_l        = (cmd_msg[15:0] == 16'h0000) ? 16'h0001 : cmd_msg[15:0];
               m_exp_sum  = job_sum(m_count, cmd_msg[15:0]);
               m_sent     = 0; m_recvd = 0; m_inflight = 0; m_cycles = 0;
               m_phase    = (m_count == 0) ? 2 : 1;
            end
            1: begin
               m_cycles++;
               if (req_val && req_rdy) begin
                  m_l = lfsr_nx(lfsr_nx(m_l));
                  m_sent++;
                  m_inflight++;
               end
               if (resp_val && resp_rdy) begin
                  m_recvd++;
                  m_inflight--;
                  if (m_recvd == m_count) m_phase = 2;
               end
            end
            default: if (done_val && done_rdy) m_phase = 0;
         endcase
      end
   end

   // GCD unit stand-in: answers in order one cycle after a request, optionally withheld.
   initial begin
      req_rdy  = 1'b1;
      resp_val = 1'b0;
      resp_msg = 16'h0;
      forever begin
         @(posedge clk);
         #1;
         if (f_rst) begin
            rq.delete();
         end else begin
            if (f_resp && rq.size() > 0) void'(rq.pop_front());
            if (f_req) rq.push_back(16'(gcd16(32'(f_a), 32'(f_b))));
         end
         resp_val = (rq.size() > 0) && (cyc >= hold_until);
         resp_msg = resp_val ? rq[0] : 16'h0;
         req_rdy  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic start_job(input logic [15:0] cnt, input logic [15:0] seed);
      int n = 0;
      job_base = req_log.size();
      cmd_msg  = {cnt, seed};
      cmd_val  = 1'b1;
      @(negedge clk);
      while (!cmd_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_rdy) abort("cmd_fire");
      @(posedge clk);
      #1 cmd_val = 1'b0;
   endtask

   task automatic wait_done(input int delay, output logic [31:0] res);
      int n = 0;
      while (!done_val && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (!done_val) abort("done_val");
      res = done_msg;
      @(posedge clk);
      #1;
      repeat (delay) begin
         @(posedge clk);
         #1;
      end
      done_rdy = 1'b1;
      @(posedge clk);
      #1 done_rdy = 1'b0;
   endtask

   initial begin
      #2_000_000;
      abort("watchdog");
   end

   initial begin
      logic [31:0] res;
      int n;
      reset   = 1'b1;
      cmd_val = 1'b0;
      cmd_msg = 32'h0;
      done_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_req_msg",  req_msg,  32'h0);
      chk("rst_done_msg", done_msg, 32'h0);
      chk("rst_cmd_rdy",  32'(cmd_rdy), 32'd1);
      chk("rst_req_val",  32'(req_val), 32'd0);
      @(posedge clk);
      #1 checking = 1'b1;

      // Basic two-pair job.
      start_job(16'd2, 16'h0001);
      wait_done(0, res);
      chk("job2_req0", logged(job_base),     32'h0001_B400);
      chk("job2_req1", logged(job_base + 1), 32'h5A00_2D00);
      chk("job2_sum",  res,                  32'h0000_2D01);

      // Empty job goes straight to DONE.
      start_job(16'd0, 16'h1234);
      @(negedge clk);
      chk("zero_done_val", 32'(done_val), 32'd1);
      wait_done(0, res);
      chk("zero_sum",  res, 32'h0);
      chk("zero_reqs", 32'(req_log.size() - job_base), 32'd0);
      @(negedge clk);
      chk("zero_idle", 32'(cmd_rdy), 32'd1);
      @(posedge clk);
      #1;

      // Responses withheld: only MAX_INFLIGHT requests may go out.
      hold_until = cyc + 14;
      start_job(16'd5, 16'h0BAD);
      repeat (8) @(negedge clk);
      chk("hold_reqs",    32'(req_log.size() - job_base), 32'd2);
      chk("hold_req_val", 32'(req_val), 32'd0);
      @(posedge clk);
      #1;
      wait_done(0, res);
      chk("hold_sum",  res, job_sum(5, 16'h0BAD));
      chk("hold_total", 32'(req_log.size() - job_base), 32'd5);

      // Zero seed behaves as seed 1.
      start_job(16'd1, 16'h0000);
      wait_done(0, res);
      chk("seed0_req", logged(job_base), 32'h0001_B400);
      chk("seed0_sum", res, 32'h0000_0001);

      // Random request back-pressure and a stalled done consumer.
      rand_rdy = 1'b1;
      start_job(16'd100, 16'hACE1);
      wait_done(5, res);
      rand_rdy = 1'b0;
      chk("rand_sum", res, job_sum(100, 16'hACE1));

      // Reset in the middle of a job, then a clean job.
      start_job(16'd10, 16'h0001);
      n = 0;
      while ((req_log.size() - job_base) < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if ((req_log.size() - job_base) < 3) abort("mid_job_reqs");
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_cmd_rdy",  32'(cmd_rdy),  32'd1);
      chk("midrst_req_val",  32'(req_val),  32'd0);
      chk("midrst_resp_rdy", 32'(resp_rdy), 32'd0);
      @(posedge clk);
      #1;
      start_job(16'd2, 16'h0001);
`ifdef GCD_CLIENT_SRC_CYCLES_EN
      n = 0;
      while (!done_val && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("post_rst_cycles", done_cycles, 32'd3);
`endif
      wait_done(0, res);
      chk("post_rst_sum", res, 32'h0000_2D01);

      repeat (2) @(posedge clk);
      finish_bench();
   end

endmodule
`default_nettype wire
